switch_toggle_detect: RTL and testbench

Input-side front end for the staircase-lamp controller. It synchronizes and debounces up to N_SW mechanical wall switches. It issues a single-cycle restart pulse whenever any debounced switch changes position, and reports which switches moved. It also provides the XOR parity level that the lamp timer consumes, so the timer sees clean, glitch-free events instead of raw pin levels.

---
 rtl/switch_toggle_detect_pkg.sv | 24 ++
 rtl/switch_toggle_detect_debounce.sv | 70 +++++++
 rtl/switch_toggle_detect.sv | 113 +++++++++++
 tb/tb_switch_toggle_detect.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_toggle_detect_pkg.sv
// Shared types and constants for the staircase-lamp switch front end.
package switch_pkg;

  // Top-level sequencing: capture initial positions, then track changes.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default debounce counter width (about 10.5 ms at 100 MHz).
  localparam int DB_BITS_DEF = 20;

  // Width of the wrapping event counter.
  localparam int EVT_W = 8;

  // Widest switch vector the parity helper accepts.
  localparam int PAR_W = 32;

  // XOR parity of a zero-extended level vector.
  function automatic logic f_parity(input logic [PAR_W-1:0] i_vec);
    return ^i_vec;
  endfunction

endpackage

// File: rtl/switch_toggle_detect_debounce.sv
// One switch channel: 2-flop synchronizer, mismatch counter, debounced level.
// Exposes the next debounced level and a single-cycle commit strobe so the
// parent can register its outputs from the same edge as the commit.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int DB_BITS = DB_BITS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  input  logic i_en,
  input  logic i_load,
  output logic o_db_nxt,
  output logic o_chg
);

  localparam logic [DB_BITS-1:0] DB_MAX = '1;

  logic               r_meta;
  logic               r_sync;
  logic               r_db;
  logic [DB_BITS-1:0] r_cnt;

  logic               w_db_nxt;
  logic [DB_BITS-1:0] w_cnt_nxt;
  logic               w_chg;

  // Next debounced level and counter: load captures, run qualifies, else hold at 0.
  always_comb begin
    w_db_nxt  = r_db;
    w_cnt_nxt = r_cnt;
    w_chg     = 1'b0;
    if (i_load) begin
      w_db_nxt  = r_sync;
      w_cnt_nxt = '0;
    end else if (i_en) begin
      if (r_sync == r_db) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != DB_MAX) begin
        w_cnt_nxt = r_cnt + DB_BITS'(1);
      end else begin
        w_chg     = 1'b1;
        w_db_nxt  = r_sync;
        w_cnt_nxt = '0;
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // Synchronizer chain plus debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_sw;
      r_sync <= r_meta;
      r_db   <= w_db_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_db_nxt = w_db_nxt;
  assign o_chg    = w_chg;

endmodule

// File: rtl/switch_toggle_detect.sv
// Switch front end: waits out the synchronizer/debounce window after reset,
// captures initial positions, then reports each debounced change as a
// one-cycle trig with a source mask, an XOR parity level and an event count.
module switch_toggle_detect
  import switch_pkg::*;
#(
  parameter int N_SW    = 3,
  parameter int DB_BITS = DB_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw,
  output logic             ready,
  output logic             trig,
  output logic [N_SW-1:0]  src,
  output logic             parity,
  output logic [EVT_W-1:0] evt_cnt
);

  // One extra bit so the init counter can reach DB_MAX+2.
  localparam int                INIT_W    = DB_BITS + 1;
  localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'((2 ** DB_BITS) + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [INIT_W-1:0] r_init_cnt;
  logic [INIT_W-1:0] w_init_cnt_nxt;
  logic              w_load;
  logic              w_en;

  logic [N_SW-1:0]   w_db_nxt;
  logic [N_SW-1:0]   w_chg;

  logic              r_ready;
  logic              r_trig;
  logic [N_SW-1:0]   r_src;
  logic              r_parity;
  logic [EVT_W-1:0]  r_evt_cnt;

  genvar g;
  generate
    for (g = 0; g < N_SW; g++) begin : g_sw
      switch_debounce #(
        .DB_BITS (DB_BITS)
      ) u_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sw     (sw[g]),
        .i_en     (w_en),
        .i_load   (w_load),
        .o_db_nxt (w_db_nxt[g]),
        .o_chg    (w_chg[g])
      );
    end
  endgenerate

  // Next-state logic: count out the init window, then enable debouncing.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_load         = 1'b0;
    w_en           = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
        if (r_init_cnt == INIT_DONE) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_load      = 1'b0;
        end
      end
      ST_RUN: begin
        w_en = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // State, init counter and registered outputs from this edge's commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
      r_trig     <= 1'b0;
      r_src      <= '0;
      r_parity   <= 1'b0;
      r_evt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_ready    <= r_ready | w_load;
      r_trig     <= |w_chg;
      r_src      <= w_chg;
      if (w_load || w_en) begin
        r_parity <= f_parity({{(PAR_W-N_SW){1'b0}}, w_db_nxt});
      end else begin
        r_parity <= r_parity;
      end
      r_evt_cnt  <= r_evt_cnt + {{(EVT_W-1){1'b0}}, |w_chg};
    end
  end

  assign ready   = r_ready;
  assign trig    = r_trig;
  assign src     = r_src;
  assign parity  = r_parity;
  assign evt_cnt = r_evt_cnt;

endmodule

// File: tb/tb_switch_toggle_detect.sv
// Directed bench for switch_toggle_detect with N_SW=3, DB_BITS=2 (DB_MAX=3).
// Expected trig events are queued when a switch change is driven and popped
// by a negedge monitor whenever the DUT raises trig.
module tb_switch_toggle_detect;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic       ready;
  logic       trig;
  logic [2:0] src;
  logic       parity;
  logic [7:0] evt_cnt;

  typedef struct packed {
    logic [2:0] src;
    logic       par;
    logic [7:0] evt;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  int         trig_seen = 0;
  logic [2:0] db_m;
  logic [7:0] evt_m;

  switch_toggle_detect #(
    .N_SW    (3),
    .DB_BITS (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .ready   (ready),
    .trig    (trig),
    .src     (src),
    .parity  (parity),
    .evt_cnt (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Queue the event a new pin pattern must produce, then drive it.
  task automatic drive_evt(input logic [2:0] new_sw);
    exp_t e;
    e.src = new_sw ^ db_m;
    db_m  = new_sw;
    evt_m = evt_m + 8'd1;
    e.par = ^db_m;
    e.evt = evt_m;
    q.push_back(e);
    sw = new_sw;
  endtask

  task automatic sb_empty(input string tag);
    #1;
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every trig must match the oldest queued event.
  always @(negedge clk) begin
    if (rst_n && trig) begin
      trig_seen++;
      chk("sb_has_entry", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_src", 32'(src), 32'(e.src));
        chk("sb_parity", 32'(parity), 32'(e.par));
        chk("sb_evt_cnt", 32'(evt_cnt), 32'(e.evt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    sw    = 3'b101;
    db_m  = 3'b101;
    evt_m = 8'd0;
    tick(3);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_src", 32'(src), 32'd0);
    chk("rst_parity", 32'(parity), 32'd0);
    chk("rst_evt_cnt", 32'(evt_cnt), 32'd0);

    // Release: ready rises on edge 6.
    rst_n = 1'b1;
    tick(5);
    chk("init_ready_e5", 32'(ready), 32'd0);
    tick(1);
    chk("init_ready_e6", 32'(ready), 32'd1);
    chk("init_parity", 32'(parity), 32'd0);
    chk("init_trig", 32'(trig), 32'd0);
    chk("init_evt_cnt", 32'(evt_cnt), 32'd0);
    tick(3);
    sb_empty("init_no_trig");

    // Single switch change: trig exactly after edge 6, one cycle wide.
    @(negedge clk);
    drive_evt(3'b100);
    tick(5);
    chk("sw0_trig_e5", 32'(trig), 32'd0);
    tick(1);
    chk("sw0_trig_e6", 32'(trig), 32'd1);
    chk("sw0_src", 32'(src), 32'b001);
    chk("sw0_parity", 32'(parity), 32'd1);
    chk("sw0_evt_cnt", 32'(evt_cnt), 32'd1);
    tick(1);
    chk("sw0_trig_e7", 32'(trig), 32'd0);
    chk("sw0_src_clr", 32'(src), 32'd0);
    sb_empty("sw0_done");

    // 3-cycle glitch on sw[1] must not commit.
    sw = 3'b110;
    tick(3);
    sw = 3'b100;
    tick(10);
    sb_empty("glitch_no_trig");
    chk("glitch_parity", 32'(parity), 32'd1);
    chk("glitch_evt_cnt", 32'(evt_cnt), 32'd1);

    // Held change on sw[1] commits once.
    drive_evt(3'b110);
    tick(8);
    sb_empty("sw1_done");

    // Two switches together: one trig, parity unchanged.
    drive_evt(3'b011);
    tick(8);
    sb_empty("pair_done");
    chk("pair_parity", 32'(parity), 32'd0);
    chk("pair_evt_cnt", 32'(evt_cnt), 32'd3);

    // 256 toggles on sw[2]: event counter wraps back to its start value.
    t0 = trig_seen;
    for (int i = 0; i < 256; i++) begin
      drive_evt(sw ^ 3'b100);
      tick(7);
    end
    sb_empty("wrap_done");
    chk("wrap_trig_count", 32'(trig_seen - t0), 32'd256);
    chk("wrap_evt_cnt", 32'(evt_cnt), 32'd3);

    // Reset two cycles into a sw[0] debounce.
    sw = sw ^ 3'b001;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_trig", 32'(trig), 32'd0);
    chk("mid_rst_src", 32'(src), 32'd0);
    chk("mid_rst_parity", 32'(parity), 32'd0);
    chk("mid_rst_evt_cnt", 32'(evt_cnt), 32'd0);
    @(negedge clk);
    tick(2);
    db_m  = sw;
    evt_m = 8'd0;
    rst_n = 1'b1;
    tick(5);
    chk("rerst_ready_e5", 32'(ready), 32'd0);
    tick(1);
    chk("rerst_ready_e6", 32'(ready), 32'd1);
    chk("rerst_parity", 32'(parity), 32'(^sw));
    tick(10);
    sb_empty("rerst_no_aborted_trig");
    chk("rerst_evt_cnt", 32'(evt_cnt), 32'd0);

    // Captured levels match the pins: a fresh sw[1] change reports only bit 1.
    drive_evt(sw ^ 3'b010);
    tick(8);
    sb_empty("rerst_sw1_done");
    chk("rerst_final_evt", 32'(evt_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
